// File: rtl/result_stream_buffer_pkg.sv
// Shared helpers for the result stream buffer: round-half-up/saturate conversion and width helpers.
package result_stream_buffer_pkg;

  localparam int data_w = 64;
  localparam int calc_w = data_w + 1;

  function automatic int ptr_w_of(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int lvl_w_of(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // One guard bit above the widest input keeps the rounding add from wrapping.
  function automatic logic signed [calc_w-1:0] scaled(input logic signed [data_w-1:0] x,
                                                      input int in_w, input int out_w);
    logic signed [calc_w-1:0] r;
    logic signed [calc_w-1:0] half;
    r    = calc_w'(x);
    half = calc_w'(1);
    if (in_w > out_w) r = r + (half <<< (in_w - out_w - 1));
    return r >>> (in_w - out_w);
  endfunction

  function automatic logic signed [calc_w-1:0] lim_hi(input int out_w);
    logic signed [calc_w-1:0] one;
    one = calc_w'(1);
    return (one <<< (out_w - 1)) - one;
  endfunction

  function automatic logic signed [calc_w-1:0] lim_lo(input int out_w);
    logic signed [calc_w-1:0] one;
    one = calc_w'(1);
    return -(one <<< (out_w - 1));
  endfunction

  function automatic logic signed [calc_w-1:0] round_sat(input logic signed [data_w-1:0] x,
                                                         input int in_w, input int out_w);
    logic signed [calc_w-1:0] v;
    v = scaled(x, in_w, out_w);
    if (v > lim_hi(out_w)) return lim_hi(out_w);
    if (v < lim_lo(out_w)) return lim_lo(out_w);
    return v;
  endfunction

  function automatic logic sat_hit(input logic signed [data_w-1:0] x,
                                   input int in_w, input int out_w);
    logic signed [calc_w-1:0] v;
    v = scaled(x, in_w, out_w);
    return (v > lim_hi(out_w)) || (v < lim_lo(out_w));
  endfunction

endpackage

// File: rtl/result_stream_buffer_fifo.sv
// First-word-fall-through FIFO with wrapping pointers; a push into a full FIFO is legal only
// alongside a pop, which the caller guarantees.
module result_fifo
  import result_stream_buffer_pkg::*;
#(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [width-1:0]             wr_data,
  output logic [width-1:0]             rd_data,
  output logic [lvl_w_of(depth)-1:0]   level
);
  localparam int ptr_w = ptr_w_of(depth);
  localparam int lvl_w = lvl_w_of(depth);

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wptr;
  logic [ptr_w-1:0] rptr;

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + ptr_w'(1);
      if (pop)  rptr <= rptr + ptr_w'(1);
      if (push && !pop)      level <= level + lvl_w'(1);
      else if (pop && !push) level <= level - lvl_w'(1);
    end
  end

  // Stale storage is never shown: an empty FIFO presents zero.
  assign rd_data = (level != '0) ? mem[rptr] : '0;

endmodule

// File: rtl/result_stream_buffer.sv
// Rounds and saturates filter results to out_w bits and queues them on a valid/ready stream;
// words arriving at a full FIFO are dropped and counted rather than back-pressured.
module result_stream_buffer
  import result_stream_buffer_pkg::*;
#(
  parameter int in_w  = 32,
  parameter int out_w = 16,
  parameter int depth = 8,
  parameter int cnt_w = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [in_w-1:0]            in_data,
  input  logic                       in_valid,
  input  logic                       flush,
  output logic [out_w-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       sat_pulse,
  output logic                       overflow,
  output logic [cnt_w-1:0]           drop_count,
  output logic [lvl_w_of(depth)-1:0] level
);
  localparam int lvl_w = lvl_w_of(depth);

  logic signed [data_w-1:0] in_ext;
  logic [out_w-1:0]         conv_word;
  logic                     conv_sat;
  logic [out_w-1:0]         st_data;
  logic                     st_vld;
  logic                     st_sat;
  logic                     push;
  logic                     pop;
  logic                     drop;

  assign in_ext    = data_w'(signed'(in_data));
  assign conv_word = out_w'(round_sat(in_ext, in_w, out_w));
  assign conv_sat  = sat_hit(in_ext, in_w, out_w);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_vld  <= 1'b0;
      st_sat  <= 1'b0;
      st_data <= '0;
    end else if (flush) begin
      st_vld  <= 1'b0;
      st_sat  <= 1'b0;
    end else begin
      st_vld <= in_valid;
      if (in_valid) begin
        st_data <= conv_word;
        st_sat  <= conv_sat;
      end
    end
  end

  // A full FIFO still takes a word when the consumer frees a slot in the same cycle.
  assign pop  = out_valid && out_ready;
  assign push = st_vld && ((level < lvl_w'(depth)) || pop);
  assign drop = st_vld && !push;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_pulse  <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (flush) begin
      sat_pulse  <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      sat_pulse <= push && st_sat;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + cnt_w'(1);
      end
    end
  end

  result_fifo #(
    .width (out_w),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (st_data),
    .rd_data (out_data),
    .level   (level)
  );

  assign out_valid = (level != '0);

endmodule

// File: tb/tb_result_stream_buffer.sv
// Directed bench for result_stream_buffer at in_w=32, out_w=16, depth=8.
module tb_result_stream_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        flush;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        sat_pulse;
  logic        overflow;
  logic [15:0] drop_count;
  logic [3:0]  level;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  result_stream_buffer #(
    .in_w(32), .out_w(16), .depth(8), .cnt_w(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sat_pulse  (sat_pulse),
    .overflow   (overflow),
    .drop_count (drop_count),
    .level      (level)
  );

  typedef struct {
    logic [31:0] din;
    logic [15:0] dout;
    logic        sat;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " out_valid"},  32'(out_valid),  32'd0);
    check({tag, " out_data"},   32'(out_data),   32'd0);
    check({tag, " sat_pulse"},  32'(sat_pulse),  32'd0);
    check({tag, " overflow"},   32'(overflow),   32'd0);
    check({tag, " drop_count"}, 32'(drop_count), 32'd0);
    check({tag, " level"},      32'(level),      32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h0001_8000, 16'h0002, 1'b0};
    vecs[1]  = '{32'h0001_7FFF, 16'h0001, 1'b0};
    vecs[2]  = '{32'hFFFF_8000, 16'h0000, 1'b0};
    vecs[3]  = '{32'h7FFF_8000, 16'h7FFF, 1'b1};
    vecs[4]  = '{32'h8000_0000, 16'h8000, 1'b0};
    vecs[5]  = '{32'h1234_5678, 16'h1234, 1'b0};
    vecs[6]  = '{32'h1234_8000, 16'h1235, 1'b0};
    vecs[7]  = '{32'h7FFF_7FFF, 16'h7FFF, 1'b0};
    vecs[8]  = '{32'hFFFF_FFFF, 16'h0000, 1'b0};
    vecs[9]  = '{32'h8000_8000, 16'h8001, 1'b0};
    vecs[10] = '{32'hFFFF_7FFF, 16'hFFFF, 1'b0};

    rst = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    #2;
    check_idle("reset");
    tick();
    rst = 1'b1;
    tick();

    // Conversion vectors: word in cycle k is visible at the output in cycle k+2.
    foreach (vecs[i]) begin
      in_data = vecs[i].din; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d k+1 out_valid", i), 32'(out_valid), 32'd0);
      tick();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d out_data", i),  32'(out_data),  32'(vecs[i].dout));
      check($sformatf("vec%0d sat_pulse", i), 32'(sat_pulse), 32'(vecs[i].sat));
      tick();
      check($sformatf("vec%0d drained", i), 32'(level), 32'd0);
    end

    // Overflow: ten words into a stalled 8-deep FIFO.
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_data = 32'(c + 1) << 16; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("ovf first drop", 32'(drop_count), 32'd1);
    tick();
    tick();
    check("ovf level",      32'(level),      32'd8);
    check("ovf drop_count", 32'(drop_count), 32'd2);
    check("ovf overflow",   32'(overflow),   32'd1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("ovf hold%0d", c), 32'(out_data), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      check($sformatf("drain%0d data", c), 32'(out_data), 32'(c + 1));
      tick();
    end
    check("drain empty", 32'(out_valid), 32'd0);
    check("drain sticky overflow", 32'(overflow), 32'd1);

    // Flush with an arriving word at level 5.
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_data = 32'(c + 1) << 16; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("pre-flush level", 32'(level), 32'd5);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h0042_0000;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_idle("flush");
    tick();
    tick();
    check("flush word lost", 32'(level), 32'd0);

    // Full FIFO with simultaneous pop and push: level stays at depth, nothing dropped.
    for (int c = 0; c < 20; c++) begin
      in_data = 32'(c + 1) << 16; in_valid = 1'b1;
      out_ready = (c >= 9);
      if (c >= 9) begin
        check($sformatf("full c%0d level", c), 32'(level),    32'd8);
        check($sformatf("full c%0d data", c),  32'(out_data), 32'(c - 8));
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("full drop_count", 32'(drop_count), 32'd0);
    check("full overflow",   32'(overflow),   32'd0);
    for (int c = 0; c < 12; c++) tick();
    check("full drained", 32'(level), 32'd0);

    // Asynchronous reset in the middle of an overflowing burst.
    out_ready = 1'b0;
    for (int c = 0; c < 11; c++) begin
      in_data = 32'(c + 1) << 16; in_valid = 1'b1;
      tick();
    end
    check("pre-rst overflow", 32'(overflow), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_idle("async rst");
    #2;
    in_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    tick();
    out_ready = 1'b1;
    in_data = 32'h0005_8000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post-rst k+1", 32'(out_valid), 32'd0);
    tick();
    check("post-rst k+2 valid", 32'(out_valid), 32'd1);
    check("post-rst k+2 data",  32'(out_data),  32'h6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/result_stream_buffer.md
# result_stream_buffer

Output stage placed directly downstream of the two-stage batch filter. It accepts the filter's decimated `out`/`valid` result stream and rounds and saturates each word to a narrower signed width. Words are held in a small FIFO and presented on a valid/ready stream, so a stalled consumer never blocks the filter. Overflow is reported and counted, never back-pressured.

## Interface
- `in_w`, default 32: width of filter result word (two's complement, fixed point).
- `out_w`, default 16: width of output word; must satisfy 2 ≤ `out_w` ≤ `in_w`.
- `depth`, default 8: FIFO entries; power of two, ≥ 2.
- `cnt_w`, default 16: width of drop counter.
- `clk`, in, 1: the single clock; all logic rising-edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `in_data`, in, `in_w`: filter result word.
- `in_valid`, in, 1: one-cycle qualifier for `in_data`; no back-pressure.
- `flush`, in, 1: synchronous clear of pipeline, FIFO, flags, counter.
- `out_data`, out, `out_w`: head-of-FIFO word.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: consumer accepts when high together with `out_valid`.
- `sat_pulse`, out, 1: one-cycle pulse when a stored word was saturated.
- `overflow`, out, 1: sticky; set on first dropped word.
- `drop_count`, out, `cnt_w`: number of dropped words; saturates at all-ones.
- `level`, out, clog2(`depth`)+1: current FIFO occupancy.

## Operation
- Stage 1, registered conversion on `in_valid`:
  - Let shift = `in_w` − `out_w`. Add 2^(shift−1) when shift > 0, giving round-half-up.
  - Arithmetic-shift right by shift.
  - Clamp to [−2^(`out_w`−1), 2^(`out_w`−1)−1].
  - Do all arithmetic in `in_w`+1 bits so the rounding add cannot wrap.
  - When shift = 0, pass the word unchanged with no rounding.
- The stage register holds data, a valid bit and a saturation bit.
- Stage 2, FIFO write when the stage valid bit is high:
  - Write is accepted if `level` < `depth`, or if a pop (`out_valid`&&`out_ready`) happens in the same cycle.
  - An accepted write produces `sat_pulse` = saturation bit in the following cycle.
  - A rejected write discards the word, sets `overflow`, and increments `drop_count` (saturating). No `sat_pulse` is produced.
- Output: first-word-fall-through.
  - `out_valid` = (`level` ≠ 0).
  - `out_data` is stable while `out_valid` && !`out_ready`.
- Pointers are clog2(`depth`) bits and wrap naturally. `level` is updated as +1 for write, −1 for pop, unchanged for both or neither.
- `flush` (synchronous) has priority over everything:
  - Clears stage valid, pointers, `level`, `overflow`, `drop_count`, `sat_pulse`.
  - A word arriving with `in_valid` in the flush cycle is discarded and not counted.
- Reset values (async, `rst` low): `out_valid`=0, `out_data`=0, `sat_pulse`=0, `overflow`=0, `drop_count`=0, `level`=0, stage valid=0. Storage contents are don't-care but are never presented.

## Timing
- Latency: `in_valid` in cycle k → write at the end of k+1 → `out_valid` high in k+2 (empty FIFO case).
- Throughput: one word per cycle in and out.
- Full FIFO with a pop and a write in the same cycle: write accepted, `level` unchanged.
- Full FIFO with no pop: write rejected, `drop_count`+1 in the next cycle.
- Empty FIFO: a pop is impossible because `out_valid`=0. A write into an empty FIFO does not bypass; it still takes the k+2 latency.
- Reset asserted mid-stream: all state clears immediately. After deassertion, the first `in_valid` follows the normal latency.
- `drop_count` at all-ones stays all-ones; `overflow` stays high.

## Structure
- Shared package (`Util`):
  - Round/saturate function parameterised on in and out widths.
  - clog2-based width constants for `level` and pointers.
- One sub-module, `result_fifo`: storage array, wrapping read/write pointers, `level`, push/pop with simultaneous-access rule.
- The top level holds the conversion stage, drop/overflow logic and flush fan-out.

## Test plan
- `in_w`=32, `out_w`=16: input 0x0001_8000 → output 0x0002. Input 0x0001_7FFF → 0x0001. Input 0xFFFF_8000 (−0.5 LSB) → 0x0000 (half-up).
- Input 0x7FFF_8000 → 0x7FFF with `sat_pulse`. Input 0x8000_0000 → 0x8000 with no `sat_pulse`.
- `out_ready`=0, 10 consecutive `in_valid` words with `depth`=8:
  - 8 stored; `level`=8.
  - `drop_count`=2, `overflow`=1.
  - On release of `out_ready`, the 8 words drain in order, and `out_data` is held while stalled.
- Full FIFO, `out_ready`=1 and continuous input: no drops, `level` stays 8.
- `flush` asserted with `in_valid` and `level`=5: next cycle `level`=0, `overflow`=0, `drop_count`=0, `out_valid`=0, and that word is lost.
- Assert `rst` low mid-burst: outputs go to reset values asynchronously (before the next clock edge). After release, one input appears on the output at k+2.
